sensor_request_scheduler: RTL and testbench
===========================================

Name: sensor_request_scheduler

Overview:
- Queued command dispatcher for the multi-sensor system.
- Accepts 2-byte request packets (command + address) from the UART RX packet buffer and buffers them in a FIFO.
- Dispatches each request to one of NUM_SENSORS sensor interfaces, with per-request timeout and checksum validation.
- Returns a 2-byte response packet (code + value) to the UART TX packet buffer via a valid/ready handshake.

Parameters:
- NUM_SENSORS, 4, number of sensor channels; valid addresses are 0..NUM_SENSORS-1 (max 32).
- DEPTH, 4, request FIFO depth in packets (power of two, ≥2).
- TIMEOUT_CYCLES, 5000000, cycles to wait for sensor_done before declaring a sensor error (100 ms at 50 MHz).

Ports:
- clock_50Mhz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  one-cycle pulse: request packet available.
- cmd_byte  input  8  requested command.
- addr_byte  input  8  sensor address.
- cmd_ready  output  1  high when the FIFO is not full.
- overflow  output  1  sticky: a request was dropped because the FIFO was full.
- sensor_enable  output  NUM_SENSORS  one-hot start pulse to the addressed sensor interface.
- sensor_done  input  NUM_SENSORS  per-channel one-cycle pulse: the 40-bit reading is valid.
- sensor_data  input  40*NUM_SENSORS  channel k occupies bits [40k+39:40k]; byte order is hum_int, hum_dec, temp_int, temp_dec, checksum (MSB first).
- rsp_valid  output  1  response packet valid.
- rsp_data  output  16  [15:8] response code, [7:0] value.
- rsp_ready  input  1  downstream accepts the response.

Behaviour:
- Reset: all outputs go low, except cmd_ready=1. FIFO is emptied, FSM enters IDLE, timeout counter is 0, overflow is 0.
- FIFO push: when cmd_valid=1 and not full, push {cmd_byte, addr_byte}. When full, drop the packet and set overflow=1; overflow clears only on reset.
  - Simultaneous push and pop are both honoured and leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Command decode:
  - 0x00 status: read sensor; response is 0x08,0x00 on success.
  - 0x01 temperature: response is 0x0A,temp_int.
  - 0x02 humidity: response is 0x09,hum_int.
  - Any other command: response is 0xFE,0x00, with no sensor access.
  - Address ≥ NUM_SENSORS (with a valid command): response is 0xFD,addr_byte, with no sensor access. Invalid command takes priority over invalid address.
- FSM states:
  - IDLE: if the FIFO is not empty, pop into current-request registers and go to DECODE.
  - DECODE: if invalid, load the response and go to RESPOND. Otherwise register sensor_enable[addr]=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
  - WAIT: only sensor_done[addr] is honoured; other channels' done pulses are ignored.
    - On done, capture that channel's 40 bits and go to EVAL.
    - Otherwise increment the counter; at TIMEOUT_CYCLES, load 0x1F,0x00 and go to RESPOND.
    - If done and timeout coincide, done wins.
  - EVAL: checksum is valid when byte4 == (byte0+byte1+byte2+byte3) mod 256.
    - On failure, respond 0x1F,0x00.
    - On success, respond per command.
    - Go to RESPOND.
  - RESPOND: rsp_valid=1 and rsp_data held stable until a cycle with rsp_ready=1. On that cycle the transfer completes; rsp_valid drops the next cycle and the FSM goes to IDLE.
- Ordering: requests complete strictly in FIFO order; one request is outstanding at a time.
- Latency (FIFO empty, FSM IDLE, cmd_valid sampled at edge N):
  - sensor_enable is high during cycle N+3.
  - For an invalid request, rsp_valid rises at N+3.
  - For a valid request, rsp_valid rises 2 cycles after the sampled sensor_done.
- Reset mid-operation: immediately abort. Pending FIFO entries and any captured response are discarded, and sensor_enable is forced low.

Test Plan (NUM_SENSORS=4, DEPTH=2, TIMEOUT_CYCLES=100):
1. cmd 0x01 addr 2; sensor_done[2] 10 cycles later with data 0x37_00_19_00_50 → one-cycle sensor_enable=4'b0100; rsp_data=0x0A19 held until rsp_ready; no other enable activity.
2. cmd 0x02 addr 1; data 0x37_00_19_00_51 (bad checksum) → rsp_data=0x1F00.
3. cmd 0x00 addr 3; never assert done; hold rsp_ready=1 → rsp_data=0x1F00 exactly 100 WAIT cycles after the enable; a sensor_done[0] pulse during WAIT is ignored.
4. Back-to-back: cmd 0x07 addr 0, then cmd 0x01 addr 9 → responses 0xFE00, then 0xFD09, in order; no sensor_enable pulses; rsp_ready held low 5 cycles on the first response keeps 0xFE00 stable.
5. Three valid cmd_valid pulses while the FSM is in WAIT with DEPTH=2 → cmd_ready=0 after the second; third packet dropped; overflow=1 stays set; exactly two further responses follow.
6. Assert reset while in WAIT with one queued request → all outputs 0, cmd_ready=1, overflow=0; no response is emitted after reset release until a new cmd_valid.

Source files
------------

// File: rtl/sensor_request_scheduler.sv
// rtl/sensor_request_scheduler.sv - queued sensor request dispatcher with timeout and checksum check
module sensor_request_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                      clock_50Mhz,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [7:0]                cmd_byte,
    input  logic [7:0]                addr_byte,
    output logic                      cmd_ready,
    output logic                      overflow,
    output logic [NUM_SENSORS-1:0]    sensor_enable,
    input  logic [NUM_SENSORS-1:0]    sensor_done,
    input  logic [40*NUM_SENSORS-1:0] sensor_data,
    output logic                      rsp_valid,
    output logic [15:0]               rsp_data,
    input  logic                      rsp_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    NUM_SENSORS_B = 8'(NUM_SENSORS);
    localparam logic [CW-1:0] TIMEOUT_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, EVAL, RESPOND} state_t;

    logic [15:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;

    state_t           state, state_next;
    logic [7:0]       cur_cmd, cur_addr;
    logic [39:0]      reading;
    logic [15:0]      rsp_reg, rsp_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [NUM_SENSORS-1:0] en_next;
    logic             cap;
    logic [AW-1:0]    sel;
    logic             cmd_ok, addr_ok, csum_ok;
    logic [7:0]       csum;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;

    always_ff @(posedge clock_50Mhz) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_byte, addr_byte};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (cmd_valid && full) overflow <= 1'b1;
        end
    end

    assign sel     = cur_addr[AW-1:0];
    assign cmd_ok  = (cur_cmd <= 8'h02);
    assign addr_ok = (cur_addr < NUM_SENSORS_B);
    assign csum    = reading[39:32] + reading[31:24] + reading[23:16] + reading[15:8];
    assign csum_ok = (csum == reading[7:0]);

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_cmd       <= '0;
            cur_addr      <= '0;
            reading       <= '0;
            rsp_reg       <= '0;
            cnt           <= '0;
            sensor_enable <= '0;
        end else begin
            state         <= state_next;
            rsp_reg       <= rsp_next;
            cnt           <= cnt_next;
            sensor_enable <= en_next;
            if (pop) {cur_cmd, cur_addr} <= fifo_mem[rd_ptr];
            if (cap) reading <= sensor_data[40*sel +: 40];
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cap        = 1'b0;
        en_next    = '0;
        cnt_next   = cnt;
        rsp_next   = rsp_reg;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Unknown command outranks an out-of-range address.
                if (!cmd_ok) begin
                    rsp_next   = 16'hFE00;
                    state_next = RESPOND;
                end else if (!addr_ok) begin
                    rsp_next   = {8'hFD, cur_addr};
                    state_next = RESPOND;
                end else begin
                    en_next    = NUM_SENSORS'(1) << sel;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (sensor_done[sel]) begin
                    cap        = 1'b1;
                    state_next = EVAL;
                end else if (cnt == TIMEOUT_LAST) begin
                    rsp_next   = 16'h1F00;
                    state_next = RESPOND;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            EVAL: begin
                state_next = RESPOND;
                if (!csum_ok) begin
                    rsp_next = 16'h1F00;
                end else begin
                    case (cur_cmd)
                        8'h00:   rsp_next = 16'h0800;
                        8'h01:   rsp_next = {8'h0A, reading[23:16]};
                        default: rsp_next = {8'h09, reading[39:32]};
                    endcase
                end
            end
            RESPOND: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESPOND);
    assign rsp_data  = rsp_reg;

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// tb/tb_sensor_request_scheduler.sv - scoreboard bench for sensor_request_scheduler
module tb_sensor_request_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [7:0]   cmd_byte, addr_byte;
    logic         cmd_ready, overflow;
    logic [3:0]   sensor_enable;
    logic [3:0]   sensor_done;
    logic [159:0] sensor_data;
    logic         rsp_valid;
    logic [15:0]  rsp_data;
    logic         rsp_ready;

    int          checks = 0;
    int          errors = 0;
    int          rsp_count = 0;
    int          en_cycles = 0;
    logic [3:0]  last_en = '0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    sensor_request_scheduler #(
        .NUM_SENSORS(4), .DEPTH(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .clock_50Mhz(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .addr_byte(addr_byte),
        .cmd_ready(cmd_ready), .overflow(overflow),
        .sensor_enable(sensor_enable), .sensor_done(sensor_done), .sensor_data(sensor_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Responses are popped from the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got %h expected none", rsp_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (rsp_data !== exp_v) begin
                    errors++;
                    $display("FAIL rsp_data got %h expected %h", rsp_data, exp_v);
                end
            end
            rsp_count++;
        end
        if (sensor_enable !== 4'b0000) begin
            en_cycles++;
            last_en = sensor_enable;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd_byte  = c;
        addr_byte = a;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic set_data(input int ch, input logic [39:0] d);
        sensor_data[40*ch +: 40] = d;
    endtask

    task automatic pulse_done(input int ch);
        sensor_done[ch] = 1'b1;
        tick();
        sensor_done = '0;
    endtask

    task automatic wait_enable(input logic [3:0] en, output bit ok);
        int n = 0;
        while (sensor_enable !== en && n < 20) begin tick(); n++; end
        ok = (sensor_enable === en);
    endtask

    task automatic wait_rsps(input int target, input int budget, output bit ok);
        int n = 0;
        while (rsp_count < target && n < budget) begin tick(); n++; end
        ok = (rsp_count >= target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({rsp_valid, sensor_enable, cmd_ready, overflow, rsp_data} !== {1'b0, 4'b0, 1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b en=%b rdy=%b ovf=%b d=%h expected v=0 en=0 rdy=1 ovf=0 d=0000",
                     rsp_valid, sensor_enable, cmd_ready, overflow, rsp_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_temperature();
        int en0 = en_cycles;
        int r0 = rsp_count;
        bit ok;
        rsp_ready = 1'b0;
        exp_q.push_back(16'h0A19);
        send(8'h01, 8'd2);
        tick();
        checks++;
        if (sensor_enable !== 4'b0000) begin errors++; $display("FAIL temp_enable_early got %b expected 0000", sensor_enable); end
        tick();
        checks++;
        if (sensor_enable !== 4'b0100) begin errors++; $display("FAIL temp_enable_latency got %b expected 0100", sensor_enable); end
        tick();
        checks++;
        if (sensor_enable !== 4'b0000) begin errors++; $display("FAIL temp_enable_width got %b expected 0000", sensor_enable); end
        repeat (8) tick();
        set_data(2, 40'h37_00_19_00_50);
        pulse_done(2);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL temp_rsp_early got %b expected 0", rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0A19) begin
            errors++; $display("FAIL temp_rsp_latency got v=%b d=%h expected v=1 d=0a19", rsp_valid, rsp_data);
        end
        repeat (3) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0A19) begin
                errors++; $display("FAIL temp_rsp_hold got v=%b d=%h expected v=1 d=0a19", rsp_valid, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        wait_rsps(r0 + 1, 5, ok);
        rsp_ready = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL temp_rsp_timeout got %0d expected %0d", rsp_count, r0 + 1); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL temp_rsp_drop got %b expected 0", rsp_valid); end
        checks++;
        if (en_cycles - en0 !== 1 || last_en !== 4'b0100) begin
            errors++; $display("FAIL temp_enable_count got %0d/%b expected 1/0100", en_cycles - en0, last_en);
        end
    endtask

    task automatic test_bad_checksum();
        int r0 = rsp_count;
        bit ok;
        rsp_ready = 1'b1;
        exp_q.push_back(16'h1F00);
        send(8'h02, 8'd1);
        wait_enable(4'b0010, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL csum_enable got %b expected 0010", sensor_enable); end
        repeat (3) tick();
        set_data(1, 40'h37_00_19_00_51);
        pulse_done(1);
        wait_rsps(r0 + 1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL csum_rsp_timeout got %0d expected %0d", rsp_count, r0 + 1); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int r0 = rsp_count;
        int k = 0;
        bit ok;
        rsp_ready = 1'b1;
        exp_q.push_back(16'h1F00);
        set_data(0, 40'h37_00_19_00_50);
        send(8'h00, 8'd3);
        wait_enable(4'b1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_enable got %b expected 1000", sensor_enable); end
        while (rsp_valid !== 1'b1 && k < 200) begin
            if (k == 20) sensor_done[0] = 1'b1;
            tick();
            sensor_done = '0;
            k++;
        end
        checks++;
        if (k !== 100) begin errors++; $display("FAIL tmo_cycles got %0d expected 100", k); end
        wait_rsps(r0 + 1, 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_rsp_count got %0d expected %0d", rsp_count, r0 + 1); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int en0 = en_cycles;
        int r0 = rsp_count;
        logic [15:0] held;
        bit ok;
        rsp_ready = 1'b0;
        exp_q.push_back(16'hFE00);
        exp_q.push_back(16'hFD09);
        send(8'h07, 8'd0);
        cmd_valid = 1'b1; cmd_byte = 8'h01; addr_byte = 8'd9;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_rsp_early got %b expected 0", rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFE00) begin
            errors++; $display("FAIL b2b_invalid_latency got v=%b d=%h expected v=1 d=fe00", rsp_valid, rsp_data);
        end
        held = rsp_data;
        repeat (5) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== held) begin
                errors++; $display("FAIL b2b_hold got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, held);
            end
        end
        rsp_ready = 1'b1;
        wait_rsps(r0 + 2, 20, ok);
        rsp_ready = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_rsp_count got %0d expected %0d", rsp_count, r0 + 2); end
        checks++;
        if (en_cycles !== en0) begin errors++; $display("FAIL b2b_no_enable got %0d expected %0d", en_cycles - en0, 0); end
    endtask

    task automatic test_overflow();
        int r0 = rsp_count;
        bit ok;
        rsp_ready = 1'b1;
        set_data(0, 40'h37_00_19_00_50);
        set_data(1, 40'h2A_00_10_00_3A);
        exp_q.push_back(16'h0A19);
        exp_q.push_back(16'h092A);
        exp_q.push_back(16'hFE00);
        send(8'h01, 8'd0);
        wait_enable(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_enable got %b expected 0001", sensor_enable); end
        send(8'h02, 8'd1);
        send(8'h07, 8'd0);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ovf_cmd_ready got %b expected 0", cmd_ready); end
        send(8'h01, 8'd3);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow); end
        pulse_done(0);
        wait_enable(4'b0010, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_enable2 got %b expected 0010", sensor_enable); end
        pulse_done(1);
        wait_rsps(r0 + 3, 30, ok);
        repeat (20) tick();
        checks++;
        if (rsp_count - r0 !== 3) begin errors++; $display("FAIL ovf_rsp_count got %0d expected 3", rsp_count - r0); end
        checks++;
        if (overflow !== 1'b1 || exp_q.size() !== 0) begin
            errors++; $display("FAIL ovf_sticky got ovf=%b pending=%0d expected ovf=1 pending=0", overflow, exp_q.size());
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int en0;
        int r0;
        bit ok;
        rsp_ready = 1'b1;
        send(8'h01, 8'd2);
        wait_enable(4'b0100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_enable got %b expected 0100", sensor_enable); end
        send(8'h02, 8'd1);
        reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, sensor_enable, cmd_ready, overflow, rsp_data} !== {1'b0, 4'b0, 1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b en=%b rdy=%b ovf=%b d=%h expected v=0 en=0 rdy=1 ovf=0 d=0000",
                     rsp_valid, sensor_enable, cmd_ready, overflow, rsp_data);
        end
        tick();
        reset = 1'b0;
        en0 = en_cycles;
        r0 = rsp_count;
        repeat (5) tick();
        pulse_done(2);
        pulse_done(1);
        repeat (20) tick();
        checks++;
        if (rsp_count !== r0 || en_cycles !== en0) begin
            errors++; $display("FAIL rst_quiet got rsp=%0d en=%0d expected 0 0", rsp_count - r0, en_cycles - en0);
        end
        exp_q.push_back(16'hFE00);
        send(8'h05, 8'd0);
        wait_rsps(r0 + 1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_new_rsp got %0d expected %0d", rsp_count, r0 + 1); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_byte    = '0;
        addr_byte   = '0;
        sensor_done = '0;
        sensor_data = '0;
        rsp_ready   = 1'b0;
        test_reset();
        test_temperature();
        test_bad_checksum();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
